// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci generator / index pair.
package fib_pkg;

  localparam int FIB_WIDTH     = 10;
  localparam int FIB_IDX_WIDTH = 5;

  // Index convention: F(0)=0, F(1)=1.
  localparam int F0 = 0;
  localparam int F1 = 1;

  // State encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SEARCH = ST_SEARCH,
    DONE   = ST_DONE
  } fib_state_t;

endpackage

// File: rtl/fibonacci_index.sv
// Inverse Fibonacci: finds the largest n with F(n) <= value, one index
// step per clock, and reports n, F(n), the remainder and an exact flag.
module fibonacci_index
  import fib_pkg::*;
#(
  parameter int WIDTH     = FIB_WIDTH,
  parameter int IDX_WIDTH = FIB_IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     value,
  output logic [IDX_WIDTH-1:0] result_n,
  output logic [WIDTH-1:0]     fib_value,
  output logic [WIDTH-1:0]     remainder,
  output logic                 exact,
  output logic                 done_tick,
  output logic                 busy
);

  fib_state_t           r_state;
  logic [WIDTH-1:0]     r_v;  // latched operand
  logic [WIDTH-1:0]     r_a;  // F(k); never exceeds r_v so WIDTH bits suffice
  logic [WIDTH:0]       r_b;  // F(k+1); one extra bit so it can exceed r_v
  logic [IDX_WIDTH-1:0] r_k;

  // Next Fibonacci term is formed at WIDTH+1 bits so it can never wrap.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_rem;
  logic             w_b_gt_v;

  assign w_sum    = {1'b0, r_a} + r_b;
  assign w_rem    = r_v - r_a;
  assign w_b_gt_v = r_b > {1'b0, r_v};

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_v       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_k       <= '0;
      result_n  <= '0;
      fib_value <= '0;
      remainder <= '0;
      exact     <= 1'b0;
      done_tick <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done_tick <= 1'b0;
          if (start) begin
            r_v     <= value;
            r_a     <= WIDTH'(F0);
            r_b     <= (WIDTH + 1)'(F1);
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_b_gt_v) begin
            // F(k+1) overshoots: k is the largest index, including the
            // value=1 tie where F(1)=F(2) and we walk on to k=2.
            result_n  <= r_k;
            fib_value <= r_a;
            remainder <= w_rem;
            exact     <= (r_v == r_a);
            done_tick <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_a <= r_b[WIDTH-1:0];
            r_b <= w_sum;
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          done_tick <= 1'b0;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_index.sv
// Self-checking bench for fibonacci_index against a table-lookup model.
module tb_fibonacci_index;
  import fib_pkg::*;

  localparam int W  = FIB_WIDTH;
  localparam int IW = FIB_IDX_WIDTH;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  value;
  logic [IW-1:0] result_n;
  logic [W-1:0]  fib_value;
  logic [W-1:0]  remainder;
  logic          exact;
  logic          done_tick;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int fib_tab[0:24];

  fibonacci_index #(.WIDTH(W), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .result_n(result_n), .fib_value(fib_value), .remainder(remainder),
    .exact(exact), .done_tick(done_tick), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: scan the Fibonacci table for the largest index <= v.
  function automatic int ref_n(input int v);
    int n = 0;
    for (int i = 0; i <= 24; i++) if (fib_tab[i] <= v) n = i;
    return n;
  endfunction

  // Count edges after the accept edge until done_tick (bounded).
  task automatic wait_done(input int already, output int lat);
    lat = already;
    while (done_tick !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_timeout", {31'd0, done_tick}, 32'd1);
  endtask

  // One full transaction with result, latency and handshake checks.
  task automatic run_val(input string tag, input int v);
    int lat;
    int n;
    n = ref_n(v);
    @(negedge clk);
    start = 1'b1;
    value = W'(v);
    @(posedge clk); #1;
    check({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    value = W'($urandom);  // must not disturb the search
    wait_done(0, lat);
    check({tag, "_lat"}, lat, n + 1);
    check({tag, "_n"}, result_n, n);
    check({tag, "_fib"}, fib_value, fib_tab[n]);
    check({tag, "_rem"}, remainder, v - fib_tab[n]);
    check({tag, "_exact"}, {31'd0, exact}, (v == fib_tab[n]) ? 1 : 0);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_tick_low"}, {31'd0, done_tick}, 32'd0);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int ticks;
    int v;

    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int i = 2; i <= 24; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_n", result_n, 0);
    check("rst_fib", fib_value, 0);
    check("rst_rem", remainder, 0);
    check("rst_exact", {31'd0, exact}, 0);
    check("rst_tick", {31'd0, done_tick}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Boundaries and directed values.
    run_val("v0", 0);
    run_val("v1", 1);
    run_val("v100", 100);
    run_val("v987", 987);
    run_val("v1023", 1023);

    // Outputs hold after completion while idle.
    repeat (3) @(posedge clk);
    #1;
    check("hold_n", result_n, 16);
    check("hold_rem", remainder, 36);

    // Start held every cycle during a value=100 search; other value on bus.
    @(negedge clk);
    start = 1'b1;
    value = W'(100);
    @(posedge clk); #1;  // E0
    ticks = 0;
    @(negedge clk);
    value = W'(777);
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (done_tick === 1'b1) ticks++;
      if (c == 12) begin
        check("hammer_tick_e12", {31'd0, done_tick}, 1);
        check("hammer_n", result_n, 11);
        check("hammer_fib", fib_value, 89);
        check("hammer_rem", remainder, 11);
      end
    end
    check("hammer_ticks", ticks, 1);
    check("hammer_busy_e13", {31'd0, busy}, 0);
    @(posedge clk); #1;  // E0+14: start accepted again
    check("hammer_reaccept", {31'd0, busy}, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(0, lat);
    check("hammer2_lat", lat, ref_n(777) + 1);
    check("hammer2_n", result_n, ref_n(777));
    check("hammer2_fib", fib_value, fib_tab[ref_n(777)]);
    @(posedge clk); #1;

    // Reset mid-search of 500, with a start on the reset edge.
    @(negedge clk);
    start = 1'b1;
    value = W'(500);
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    value = W'(55);
    @(posedge clk); #1;
    check("mid_rst_n", result_n, 0);
    check("mid_rst_fib", fib_value, 0);
    check("mid_rst_rem", remainder, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_tick", {31'd0, done_tick}, 0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done_tick === 1'b1 || busy === 1'b1) ticks++;
    end
    check("mid_rst_quiet", ticks, 0);
    run_val("v55", 55);

    // Round trip from generator outputs F(m).
    for (int m = 1; m <= 15; m++) begin
      run_val($sformatf("rt%0d", m), fib_tab[m]);
      check($sformatf("rt%0d_idx", m), result_n, (m == 1) ? 2 : m);
    end

    // Random operands.
    for (int r = 0; r < 25; r++) begin
      v = int'($urandom_range(0, 1023));
      run_val($sformatf("rnd%0d", r), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibonacci_index.md
# fibonacci_index

Inverse of the Fibonacci generator. Given a 10-bit value, the block iteratively finds the largest index n with F(n) ≤ value, using F(0)=0, F(1)=1. It reports n, F(n), the remainder value − F(n), and an exact-match flag. It sits beside the generator: feeding the generator's result into this block recovers the original index, and repeated use on the remainder yields a Zeckendorf decomposition.

## Interface
Parameters:
- WIDTH, 10: bit width of value, fib_value and remainder.
- IDX_WIDTH, 5: bit width of result_n; must hold the largest index reachable for WIDTH (16 for WIDTH=10).

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high; wins over every other input.
- start, input, 1: request; sampled only in IDLE.
- value, input, WIDTH: operand; sampled on the edge where start is accepted.
- result_n, output, IDX_WIDTH: largest n with F(n) ≤ value.
- fib_value, output, WIDTH: F(result_n).
- remainder, output, WIDTH: value − F(result_n).
- exact, output, 1: 1 when remainder == 0.
- done_tick, output, 1: one-cycle pulse; results are valid while it is high and afterwards.
- busy, output, 1: high from the accept edge until the block returns to IDLE.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE, start=1:
  - latch value into v.
  - a←0 (F(k)), b←1 (F(k+1)), k←0.
  - busy←1, go to SEARCH.
- IDLE, start=0: hold all outputs.
- SEARCH:
  - If b > v: result_n←k, fib_value←a, remainder←v−a, exact←(v==a), done_tick←1, go to DONE.
  - Else: a←b, b←a+b, k←k+1.
- DONE: done_tick←0, busy←0, go to IDLE.
- Width rule: b and the a+b adder are WIDTH+1 bits, so the sum never wraps. The largest b formed is F(n+1), and F(n+1) < 2·2^WIDTH. a is always ≤ v, so it fits in WIDTH bits.
- Tie at value=1: F(1)=F(2)=1; the block reports n=2 (largest index).
- Outputs result_n, fib_value, remainder and exact hold their last values until the next completion.
- start while busy (SEARCH or DONE) is ignored. It is not queued.
- A change on value after the accept edge has no effect.

## Timing
- Reset values: result_n=0, fib_value=0, remainder=0, exact=0, done_tick=0, busy=0, state=IDLE.
- Reset mid-operation: the next edge gives the reset values; the search in progress is discarded and no done_tick is produced.
- Accept edge E0 (IDLE, start=1): busy is high after E0.
- SEARCH runs exactly n+1 edges. After edge E0+n+1:
  - done_tick=1 and the results are updated.
  - busy is still 1.
- After edge E0+n+2: done_tick=0, busy=0, state is IDLE.
- A new start is accepted no earlier than edge E0+n+3.
- Latency start→done_tick is n+1 cycles: 1 cycle minimum (value=0), 17 cycles maximum (WIDTH=10, value ≥ 987).
- Start and reset on the same edge: reset wins and the start is lost.

## Structure
- Shared package fib_pkg holds:
  - state encodings IDLE/SEARCH/DONE as localparams;
  - FIB_WIDTH=10 and FIB_IDX_WIDTH=5;
  - the index convention constants F0=0, F1=1.
- The generator should use the same package for its width constants.
- No sub-module: a single always block plus a WIDTH+1 adder and a WIDTH subtractor.

## Test plan
- Reset, then value=0 with a start pulse → done_tick after 1 cycle with n=0, fib_value=0, remainder=0, exact=1; busy low 2 cycles after accept.
- value=1 → n=2, fib_value=1, remainder=0, exact=1, latency 3. value=100 → n=11, fib_value=89, remainder=11, exact=0, latency 12.
- value=987 → n=16, exact=1. value=1023 → n=16, fib_value=987, remainder=36, exact=0, latency 17, with no adder wrap.
- Start pulsed every cycle during a value=100 search with a different value on the bus → exactly one done_tick, results for 100, next accept no earlier than E0+14.
- Reset asserted at SEARCH cycle 5 of a value=500 search → all outputs 0 next cycle, no done_tick. A following start with value=55 → n=10, exact=1.
- Round trip: for m=2..15, drive the generator output F(m) into this block → result_n=m, exact=1. m=1 → result_n=2.
